pressure_controller: RTL and testbench
======================================

// Module: pressure_controller
// PURPOSE
//  Parametrised airlock chamber pressure controller; successor to the fixed 8-bit pressure block.
//  Ramps a WIDTH-bit pressure register between P_MIN and P_MAX with independent up/down steps.
//  Adds a settle interval, a done pulse, abort, command-conflict detection and a re-arm rule.
//  Sits between the airlock sequencer (issues start/abort) and the door interlock (reads status).
// PARAMETERS
//  WIDTH          8    pressure register width, in bits
//  P_MIN          0    fully depressurised level
//  P_MAX          200  fully pressurised level (P_MIN < P_MAX < 2**WIDTH)
//  STEP_UP        5    increment per cycle while pressurising (1..P_MAX-P_MIN)
//  STEP_DOWN      10   decrement per cycle while depressurising (1..P_MAX-P_MIN)
//  SETTLE_CYCLES  3    hold cycles after the target is reached, before done (>=1)
// PORTS
//  clock                  in   1      single clock; all state updates on the rising edge
//  reset                  in   1      asynchronous, active-high
//  startPressurization    in   1      request ramp to P_MAX
//  startDepressurization  in   1      request ramp to P_MIN
//  abort                  in   1      stop the current operation and hold the present pressure
//  pressure               out  WIDTH  current chamber pressure
//  busy                   out  1      high in RAMP_UP, RAMP_DOWN and SETTLE
//  done                   out  1      1-cycle pulse when an operation completes
//  aborted                out  1      1-cycle pulse when an abort is taken
//  cmd_error              out  1      1-cycle pulse when both starts are high in IDLE
//  at_high / at_low       out  1      combinational: pressure==P_MAX / pressure==P_MIN
// BEHAVIOUR
//  Reset: state=IDLE, pressure=P_MAX, busy=done=aborted=cmd_error=0, armed=1, settle count=0.
//  States: IDLE, RAMP_UP, RAMP_DOWN, SETTLE (2-bit encoding).
//  IDLE, armed=1, exactly one start high:
//   -> RAMP_UP / RAMP_DOWN on that edge; pressure unchanged on the accept edge; armed<=0.
//   If pressure is already at the target: -> SETTLE directly.
//  IDLE, both starts high: cmd_error pulse; stay in IDLE; armed unchanged.
//  armed<=1 on any IDLE edge with both starts low; a held-high start never retriggers.
//  RAMP_UP: each edge, pressure <= min(pressure+STEP_UP, P_MAX).
//   Sum is computed WIDTH+1 bits wide; no wrap-around.
//  RAMP_DOWN: each edge, pressure <= max(pressure-STEP_DOWN, P_MIN); no underflow.
//  Transition to SETTLE on the edge that writes the clamped target value.
//   Ramp length = ceil(distance/step) edges.
//  SETTLE: count SETTLE_CYCLES edges; on the last edge -> IDLE with done=1 for that cycle.
//  Starts are ignored outside IDLE (both directions); the sequencer must abort first.
//  abort in any busy state: -> IDLE next edge, pressure frozen, aborted pulse, no done.
//   abort in IDLE is ignored.
//  abort has priority over ramp and settle progress in the same cycle.
//  Reset mid-operation: immediate return to reset values; there is no partial completion.
//  Illegal parameter combinations: $display error plus $finish in an initial block.
// STRUCTURE
//  pressure_defs.vh: state localparams, STATE_W=2.
//  Sub-module pressure_ramp: saturating step datapath.
//   Inputs: pressure, up, down. Output: next pressure. Flags: hit_max, hit_min.
//  The top level holds the FSM, settle counter ($clog2(SETTLE_CYCLES+1) bits), armed flag
//   and pulse registers.
// TESTING
//  1 Reset -> pressure=200, all flags 0, at_high=1.
//    Hold startDepressurization for 30 edges -> 20 ramp edges to 0, then 3 settle edges.
//    done pulses exactly once.
//  2 From 0, pulse startPressurization -> 40 ramp edges, pressure=5,10,...,200.
//    done comes 3 edges after pressure reaches 200.
//  3 P_MAX=203, STEP_UP=5 -> last step clamps 200->203, no wrap.
//    WIDTH=8, P_MAX=255, STEP_UP=10 -> 250->255.
//  4 abort at pressure=100 mid RAMP_UP -> aborted pulse, pressure stays 100, busy=0, no done.
//  5 Both starts high in IDLE -> cmd_error pulse, no state change.
//    startPressurization while at 200 -> SETTLE then done, pressure unchanged.
//  6 Assert reset at pressure=60 during RAMP_DOWN -> pressure=200 and IDLE asynchronously.
//    startDepressurization held across completion -> no second operation until deasserted.

Source files
------------

// File: rtl/pressure_pkg.sv
// rtl/pressure_pkg.sv - state encoding shared by the pressure controller files
package pressure_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_SETTLE    = 2'd3
  } state_e;

endpackage

// File: rtl/pressure_ramp.sv
// rtl/pressure_ramp.sv - saturating one-step pressure datapath
module pressure_ramp #(
  parameter int WIDTH     = 8,
  parameter int P_MIN     = 0,
  parameter int P_MAX     = 200,
  parameter int STEP_UP   = 5,
  parameter int STEP_DOWN = 10
) (
  input  logic [WIDTH-1:0] pressure_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] pressure_o,
  output logic             hit_max_o,
  output logic             hit_min_o
);

  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(P_MAX);
  localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(P_MIN);
  localparam logic [WIDTH:0] UP_X   = (WIDTH+1)'(STEP_UP);
  localparam logic [WIDTH:0] DOWN_X = (WIDTH+1)'(STEP_DOWN);

  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] sum_x;

  // One extra bit keeps the upward sum from wrapping before the clamp.
  assign cur_x     = {1'b0, pressure_i};
  assign sum_x     = cur_x + UP_X;
  assign hit_max_o = (sum_x >= MAX_X);
  assign hit_min_o = (cur_x <= MIN_X + DOWN_X);

  always_comb begin
    pressure_o = pressure_i;
    if (up_i) begin
      pressure_o = hit_max_o ? MAX_X[WIDTH-1:0] : sum_x[WIDTH-1:0];
    end else if (down_i) begin
      pressure_o = hit_min_o ? MIN_X[WIDTH-1:0] : pressure_i - DOWN_X[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pressure_controller.sv
// rtl/pressure_controller.sv - airlock pressure ramp FSM with settle, abort and re-arm
module pressure_controller
  import pressure_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int P_MIN         = 0,
  parameter int P_MAX         = 200,
  parameter int STEP_UP       = 5,
  parameter int STEP_DOWN     = 10,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_pressurization_i,
  input  logic             start_depressurization_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] pressure_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             cmd_error_o,
  output logic             at_high_o,
  output logic             at_low_o
);

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] P_MAX_V  = WIDTH'(P_MAX);
  localparam logic [WIDTH-1:0] P_MIN_V  = WIDTH'(P_MIN);

  if (P_MIN >= P_MAX || P_MAX >= (2 ** WIDTH) || STEP_UP < 1 || STEP_UP > P_MAX - P_MIN ||
      STEP_DOWN < 1 || STEP_DOWN > P_MAX - P_MIN || SETTLE_CYCLES < 1) begin : g_bad_params
    $error("pressure_controller: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pressure_q, pressure_d, ramp_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             done_q, done_d, aborted_q, aborted_d, cmd_error_q, cmd_error_d;
  logic             hit_max, hit_min, target_hit;

  pressure_ramp #(
    .WIDTH(WIDTH), .P_MIN(P_MIN), .P_MAX(P_MAX), .STEP_UP(STEP_UP), .STEP_DOWN(STEP_DOWN)
  ) u_ramp (
    .pressure_i(pressure_q),
    .up_i      (state_q == ST_RAMP_UP),
    .down_i    (state_q == ST_RAMP_DOWN),
    .pressure_o(ramp_next),
    .hit_max_o (hit_max),
    .hit_min_o (hit_min)
  );

  assign target_hit = (state_q == ST_RAMP_UP) ? hit_max : hit_min;

  always_comb begin
    state_d     = state_q;
    pressure_d  = pressure_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cmd_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pressurization_i && start_depressurization_i) begin
          cmd_error_d = 1'b1;
        end else if (start_pressurization_i || start_depressurization_i) begin
          // Only a fresh request is accepted; a start held since the last one is ignored.
          if (armed_q) begin
            armed_d = 1'b0;
            cnt_d   = '0;
            if (start_pressurization_i) begin
              state_d = (pressure_q == P_MAX_V) ? ST_SETTLE : ST_RAMP_UP;
            end else begin
              state_d = (pressure_q == P_MIN_V) ? ST_SETTLE : ST_RAMP_DOWN;
            end
          end
        end else begin
          armed_d = 1'b1;
        end
      end
      ST_RAMP_UP, ST_RAMP_DOWN: begin
        if (abort_i) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          pressure_d = ramp_next;
          if (target_hit) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pressure_q  <= P_MAX_V;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pressure_q  <= pressure_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign pressure_o  = pressure_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign cmd_error_o = cmd_error_q;
  assign at_high_o   = (pressure_q == P_MAX_V);
  assign at_low_o    = (pressure_q == P_MIN_V);

endmodule

// File: tb/tb_pressure_controller.sv
// tb/tb_pressure_controller.sv - scoreboard bench for three parameterisations of pressure_controller
module tb_pressure_controller;

  localparam int PMAX [3] = '{200, 203, 255};
  localparam int SUP  [3] = '{5, 5, 10};
  localparam int SDN    = 10;
  localparam int PMIN   = 0;
  localparam int SETTLE = 3;

  typedef struct packed {
    logic [7:0] p;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       cmd_error;
    logic       at_high;
    logic       at_low;
  } obs_t;
  typedef obs_t [2:0] trio_t;

  logic clk = 1'b0, rst = 1'b1, sp = 1'b0, sd = 1'b0, ab = 1'b0;
  logic [7:0] pr [3];
  logic busy [3], done [3], abd [3], ce [3], hi [3], lo [3];

  int checks = 0, errors = 0, cyc = 0, done_seen = 0;
  trio_t exp_q [$];

  int m_p [3], m_dir [3], m_left [3];
  bit m_armed [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pressure_controller #(
      .WIDTH(8), .P_MIN(PMIN), .P_MAX(PMAX[g]), .STEP_UP(SUP[g]),
      .STEP_DOWN(SDN), .SETTLE_CYCLES(SETTLE)
    ) u_dut (
      .clock_i                 (clk),
      .reset_i                 (rst),
      .start_pressurization_i  (sp),
      .start_depressurization_i(sd),
      .abort_i                 (ab),
      .pressure_o              (pr[g]),
      .busy_o                  (busy[g]),
      .done_o                  (done[g]),
      .aborted_o               (abd[g]),
      .cmd_error_o             (ce[g]),
      .at_high_o               (hi[g]),
      .at_low_o                (lo[g])
    );
  end

  // Reference: each cycle, apply the operation rules to a plain integer pressure.
  task automatic step(input bit isp, input bit isd, input bit iab, input bit irs);
    trio_t e;
    int tgt;
    bit d, a, c, bz;
    @(negedge clk);
    sp = isp; sd = isd; ab = iab; rst = irs;
    for (int i = 0; i < 3; i++) begin
      d = 0; a = 0; c = 0;
      if (irs) begin
        m_p[i] = PMAX[i]; m_dir[i] = 0; m_left[i] = 0; m_armed[i] = 1;
      end else if (m_dir[i] != 0 || m_left[i] > 0) begin
        if (iab) begin
          m_dir[i] = 0; m_left[i] = 0; a = 1;
        end else if (m_dir[i] > 0) begin
          m_p[i] = m_p[i] + SUP[i];
          if (m_p[i] >= PMAX[i]) begin m_p[i] = PMAX[i]; m_dir[i] = 0; m_left[i] = SETTLE; end
        end else if (m_dir[i] < 0) begin
          m_p[i] = m_p[i] - SDN;
          if (m_p[i] <= PMIN) begin m_p[i] = PMIN; m_dir[i] = 0; m_left[i] = SETTLE; end
        end else begin
          m_left[i]--;
          if (m_left[i] == 0) d = 1;
        end
      end else if (isp && isd) begin
        c = 1;
      end else if (isp || isd) begin
        if (m_armed[i]) begin
          m_armed[i] = 0;
          tgt = isp ? PMAX[i] : PMIN;
          if (m_p[i] == tgt) m_left[i] = SETTLE;
          else m_dir[i] = isp ? 1 : -1;
        end
      end else begin
        m_armed[i] = 1;
      end
      bz = (m_dir[i] != 0) || (m_left[i] > 0);
      e[i] = {8'(m_p[i]), bz, d, a, c, m_p[i] == PMAX[i], m_p[i] == PMIN};
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin : monitor
    trio_t e;
    obs_t a;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        a = {pr[i], busy[i], done[i], abd[i], ce[i], hi[i], lo[i]};
        checks++;
        if (a !== e[i]) begin
          errors++;
          $display("FAIL cycle%0d dut%0d: got p=%0d busy=%b done=%b aborted=%b cmd_error=%b at_high=%b at_low=%b, expected p=%0d busy=%b done=%b aborted=%b cmd_error=%b at_high=%b at_low=%b",
                   cyc, i, a.p, a.busy, a.done, a.aborted, a.cmd_error, a.at_high, a.at_low,
                   e[i].p, e[i].busy, e[i].done, e[i].aborted, e[i].cmd_error, e[i].at_high, e[i].at_low);
        end
        if (i == 0 && done[0] === 1'b1) done_seen++;
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic check_done_count(input string name, input int want);
    @(posedge clk); #2;
    checks++;
    if (done_seen != want) begin
      errors++;
      $display("FAIL %s: got %0d done pulses, expected %0d", name, done_seen, want);
    end
    done_seen = 0;
  endtask

  task automatic run_until_p0(input int want, input string name);
    int n;
    n = 0;
    while (m_p[0] != want && n < 200) begin step(0, 0, 0, 0); n++; end
    if (m_p[0] != want) begin
      errors++;
      $display("FAIL %s: ramp never reached %0d (at %0d)", name, want, m_p[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_p[i] = PMAX[i]; m_dir[i] = 0; m_left[i] = 0; m_armed[i] = 1;
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    done_seen = 0;

    // Held depressurisation from reset: full ramp down, settle, single done.
    for (int k = 0; k < 30; k++) step(0, 1, 0, 0);
    idle(2);
    check_done_count("depress_done_once", 1);

    // Pulsed pressurisation from 0 to the top, including the clamped last steps.
    step(1, 0, 0, 0);
    idle(45);
    check_done_count("press_done_once", 1);

    // Abort in mid ramp at 100.
    step(0, 1, 0, 0);
    idle(30);
    step(1, 0, 0, 0);
    run_until_p0(100, "abort_setup");
    step(0, 0, 1, 0);
    idle(5);
    done_seen = 0;

    // Conflicting starts, then a start with the chamber already at target.
    step(1, 1, 0, 0);
    idle(3);
    step(1, 0, 0, 0);
    idle(30);
    step(1, 0, 0, 0);
    idle(6);

    // Asynchronous reset during a down ramp at 60.
    step(0, 1, 0, 0);
    run_until_p0(60, "reset_setup");
    step(0, 0, 0, 1);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pr[i] !== 8'(PMAX[i]) || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got p=%0d busy=%b, expected p=%0d busy=0", i, pr[i], busy[i], PMAX[i]);
      end
    end
    step(0, 0, 0, 0);
    done_seen = 0;

    // Start held past completion must not launch a second operation.
    for (int k = 0; k < 45; k++) step(0, 1, 0, 0);
    idle(2);
    check_done_count("held_start_single_op", 1);

    // Randomised traffic.
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0);
    end
    idle(4);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
